// File: rtl/rto_write_arbiter.sv
// rto_write_arbiter
// Shares the single write port of the RTO core FIFO among NUM_REQ requesters.
// A round-robin arbiter grants at most one requester per cycle. The accepted
// word goes through a one-word output stage and is written one cycle later.
// Words whose timestamp runs backwards are dropped and flag a sticky error.
// A flush request drains the output stage and then pulses fifo_flush.
//
// Ports
//   clk          sole clock
//   reset        asynchronous, active-high reset
//   req_valid    per-requester word valid
//   req_data     requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    per-requester accept (combinational)
//   flush_req    single-cycle flush request
//   err_clear    single-cycle clear of the sticky timestamp error
//   fifo_full    RTO core almost-full (at least one word of margin)
//   fifo_write   one-cycle write strobe
//   fifo_din     written word, held while fifo_write is low
//   fifo_flush   one-cycle flush strobe
//   flush_done   one-cycle pulse, coincident with fifo_flush
//   ts_error     sticky timestamp-order error
//   ts_error_id  requester that caused the first error
//   word_count   number of words written, wraps at 2^32
module rto_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 128,
  parameter int TS_LSB     = 64,
  parameter int REQ_ID_LEN = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          flush_req,
  input  logic                          err_clear,
  input  logic                          fifo_full,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          fifo_flush,
  output logic                          flush_done,
  output logic                          ts_error,
  output logic [REQ_ID_LEN-1:0]         ts_error_id,
  output logic [31:0]                   word_count
);

  typedef enum logic [1:0] {
    ARB         = 2'd0,
    FLUSH_DRAIN = 2'd1,
    FLUSH_PULSE = 2'd2
  } state_t;

  state_t                  state_r;
  logic [REQ_ID_LEN-1:0]   last_grant_r;
  logic [63:0]             last_ts_r;
  logic [31:0]             word_count_r;

  logic [REQ_ID_LEN-1:0]   cand_s;
  logic [REQ_ID_LEN-1:0]   win_idx_s;
  logic                    win_found_s;
  logic [DATA_WIDTH-1:0]   win_data_s;
  logic [63:0]             win_ts_s;
  logic                    xfer_s;
  logic                    ts_bad_s;

  assign word_count = word_count_r;

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin
    win_idx_s   = {REQ_ID_LEN{1'b0}};
    win_found_s = 1'b0;
    cand_s      = {REQ_ID_LEN{1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = REQ_ID_LEN'((int'(last_grant_r) + k) % NUM_REQ);
      if (!win_found_s && req_valid[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Grant only in ARB with FIFO margin; reset forces all readies low.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if (!reset && (state_r == ARB) && !fifo_full && win_found_s) begin
      req_ready[win_idx_s] = 1'b1;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Select the winner's data word.
  always_comb begin
    win_data_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx_s == REQ_ID_LEN'(i)) begin
        win_data_s = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        win_data_s = win_data_s;
      end
    end
  end

  assign win_ts_s = win_data_s[TS_LSB +: 64];
  assign xfer_s   = |(req_valid & req_ready);
  // Equal timestamps are legal; only a strictly older one is rejected.
  assign ts_bad_s = xfer_s && (win_ts_s < last_ts_r);

  // Arbiter state, output stage, timestamp checker and flush sequencing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ARB;
      last_grant_r <= REQ_ID_LEN'(NUM_REQ - 1);
      last_ts_r    <= 64'd0;
      word_count_r <= 32'd0;
      fifo_write   <= 1'b0;
      fifo_din     <= {DATA_WIDTH{1'b0}};
      fifo_flush   <= 1'b0;
      flush_done   <= 1'b0;
      ts_error     <= 1'b0;
      ts_error_id  <= {REQ_ID_LEN{1'b0}};
    end else begin
      fifo_write <= 1'b0;
      fifo_flush <= 1'b0;
      flush_done <= 1'b0;

      if (xfer_s) begin
        last_grant_r <= win_idx_s;
        if (!ts_bad_s) begin
          fifo_write   <= 1'b1;
          fifo_din     <= win_data_s;
          last_ts_r    <= win_ts_s;
          word_count_r <= word_count_r + 32'd1;
        end
      end

      // A fresh error beats a simultaneous clear and re-captures the id.
      if (ts_bad_s) begin
        ts_error <= 1'b1;
        if (!ts_error || err_clear) begin
          ts_error_id <= win_idx_s;
        end
      end else if (err_clear) begin
        ts_error    <= 1'b0;
        ts_error_id <= {REQ_ID_LEN{1'b0}};
      end

      // No grants outside ARB, so the drain cycle empties the output stage.
      case (state_r)
        ARB: begin
          if (flush_req) begin
            state_r <= FLUSH_DRAIN;
          end
        end
        FLUSH_DRAIN: begin
          state_r     <= FLUSH_PULSE;
          fifo_flush  <= 1'b1;
          flush_done  <= 1'b1;
          last_ts_r   <= 64'd0;
          ts_error    <= 1'b0;
          ts_error_id <= {REQ_ID_LEN{1'b0}};
        end
        FLUSH_PULSE: begin
          state_r <= ARB;
        end
        default: begin
          state_r <= ARB;
        end
      endcase
    end
  end

endmodule
